imem_loader: RTL

- Boot-time program loader that sits directly upstream of the single-cycle CPU's instruction memory.
- Accepts a length-prefixed byte stream over a valid/ready handshake and packs it big-endian into 32-bit words.
- Writes each word into instruction memory through the SRAM write port, at word-aligned byte addresses that match PC addressing.
- Holds the CPU in its PC-clear state until the whole program has been written, then releases it.

---
 rtl/imem_loader_pkg.sv | 17 +
 rtl/imem_loader_byte_packer.sv | 31 +++
 rtl/imem_loader.sv | 130 +++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_W          = 16;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Big-endian 4-byte assembler: first byte lands in [31:24]; word_full flags the 4th byte.
// Index and partial word only move on load, so valid gaps inside a word are harmless.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic        load,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_full
);

  logic [1:0]  idx;
  logic [31:0] word_q;

  // ~idx maps lane 0 to bit 24, lane 3 to bit 0.
  always_ff @(posedge clk) begin
    if (clr) begin
      idx    <= 2'd0;
      word_q <= 32'd0;
    end else if (load) begin
      word_q[{~idx, 3'b000} +: 8] <= byte_in;
      idx                         <= idx + 2'd1;
    end
  end

  assign word      = word_q;
  assign word_full = load && (idx == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into instruction memory, one word per 5 cycles,
// holding the CPU in PC-clear until the program is written; byte_ready drops in WRITE/IDLE/DONE/ERR.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int                AWIDTH   = 32,
  parameter int                DEPTH    = 1024,
  parameter logic [AWIDTH-1:0] BASEADDR = '0
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [31:0]       mem_din,
  output logic              mem_wr,
  output logic              mem_cs,
  output logic              cpu_run,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       word_cnt
);

  state_t             state, state_n;
  logic [LEN_W-1:0]   len;
  logic [LEN_W-1:0]   len_next;
  logic [15:0]        cnt;
  logic [15:0]        cnt_inc;
  logic               len_zero;
  logic               len_too_big;
  logic               data_load;
  logic               word_full;
  logic [31:0]        word;

  // Derived from state rather than byte_ready to keep the packer out of a combinational loop.
  assign data_load   = byte_valid && (state == DATA);
  assign len_next    = {len[15:8], byte_in};
  assign len_zero    = (len_next == '0);
  assign len_too_big = (32'(len_next) > 32'(DEPTH));
  assign cnt_inc     = cnt + 16'd1;

  byte_packer u_packer (
    .clk       (clk),
    .clr       (clr),
    .load      (data_load),
    .byte_in   (byte_in),
    .word      (word),
    .word_full (word_full)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      len <= '0;
      cnt <= 16'd0;
    end else begin
      if (byte_valid && (state == LEN_HI)) len[15:8] <= byte_in;
      if (byte_valid && (state == LEN_LO)) len[7:0]  <= byte_in;
      if (state == WRITE)                  cnt       <= cnt_inc;
    end
  end

  always_comb begin
    state_n    = state;
    byte_ready = 1'b0;
    mem_wr     = 1'b0;
    mem_cs     = 1'b0;
    mem_din    = 32'd0;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    cpu_run    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_n = LEN_HI;
      end
      LEN_HI: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid) state_n = LEN_LO;
      end
      LEN_LO: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid) begin
          if (len_zero)         state_n = DONE;
          else if (len_too_big) state_n = ERR;
          else                  state_n = DATA;
        end
      end
      DATA: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (word_full) state_n = WRITE;
      end
      WRITE: begin
        mem_wr  = 1'b1;
        mem_cs  = 1'b1;
        mem_din = word;
        busy    = 1'b1;
        state_n = (cnt_inc == len) ? DONE : DATA;
      end
      DONE: begin
        done    = 1'b1;
        cpu_run = 1'b1;
      end
      ERR: begin
        err = 1'b1;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Byte address tracks PC addressing: word index times four, offset by the base.
  assign mem_addr = BASEADDR + (AWIDTH'(cnt) << 2);
  assign word_cnt = cnt;

endmodule
